// File: rtl/seq_div_param.sv
// Self-sequencing restoring divider with start/ready/done handshake, signed mode,
// divide-by-zero flag and one quotient bit per RUN cycle.
module seq_div_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] din_A,
  input  logic [WIDTH-1:0] din_B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, part_rem, part_quo;
  logic [CNT_W-1:0] cnt;
  logic             sgn, neg_q, neg_r;
  logic [WIDTH:0]   trial;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // next-state decode and trial subtraction
  always_comb begin
    state_next = state;
    trial      = {part_rem, op_a[WIDTH-1]} - {1'b0, op_b};
    case (state)
      IDLE:    if (start) state_next = LOAD; else state_next = IDLE;
      LOAD:    if (op_b == '0) state_next = DONE; else state_next = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_next = FIX; else state_next = RUN;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // handshake flags, decoded from the state being entered so they are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
      busy  <= (state_next == LOAD) || (state_next == RUN) || (state_next == FIX);
      done  <= (state_next == DONE);
    end
  end

  // operand, partial result and published result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      part_rem <= '0;
      part_quo <= '0;
      cnt      <= '0;
      sgn      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= din_A;
            op_b  <= din_B;
            sgn   <= is_signed;
            neg_q <= is_signed & (din_A[WIDTH-1] ^ din_B[WIDTH-1]);
            neg_r <= is_signed & din_A[WIDTH-1];
          end
        end
        LOAD: begin
          if (op_b == '0) begin
            quo     <= '1;
            rem     <= op_a;
            div_err <= 1'b1;
          end else begin
            op_a     <= mag(op_a, sgn);
            op_b     <= mag(op_b, sgn);
            part_rem <= '0;
            part_quo <= '0;
            cnt      <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          // trial MSB clear means the shifted remainder covers the divisor
          if (!trial[WIDTH]) begin
            part_rem <= trial[WIDTH-1:0];
            part_quo <= {part_quo[WIDTH-2:0], 1'b1};
          end else begin
            part_rem <= {part_rem[WIDTH-2:0], op_a[WIDTH-1]};
            part_quo <= {part_quo[WIDTH-2:0], 1'b0};
          end
          op_a <= {op_a[WIDTH-2:0], 1'b0};
          cnt  <= cnt - CNT_W'(1);
        end
        FIX: begin
          // modulo negation also yields most-negative / -1 = most-negative, rem 0
          quo     <= neg_q ? (~part_quo + {{(WIDTH-1){1'b0}}, 1'b1}) : part_quo;
          rem     <= neg_r ? (~part_rem + {{(WIDTH-1){1'b0}}, 1'b1}) : part_rem;
          div_err <= 1'b0;
        end
        DONE: begin
          cnt <= cnt;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_param.sv
// Directed and random checks of seq_div_param (WIDTH=8) against a software
// model, using a queue scoreboard of expected results.
module tb_seq_div_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] din_A = '0;
  logic [W-1:0] din_B = '0;
  logic         ready, busy, done, div_err;
  logic [W-1:0] quo, rem;

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  seq_div_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .din_A(din_A), .din_B(din_B), .ready(ready), .busy(busy), .done(done),
    .quo(quo), .rem(rem), .div_err(div_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division; divide-by-zero gives all ones / raw dividend.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   na, nb, q, r;
    if (b == '0) begin
      e.quo = '1;
      e.rem = a;
      e.err = 1'b1;
    end else begin
      if (s) begin
        na = int'($signed(a));
        nb = int'($signed(b));
      end else begin
        na = int'(a);
        nb = int'(b);
      end
      q = na / nb;
      r = na % nb;
      e.quo = q[W-1:0];
      e.rem = r[W-1:0];
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      check("busy_ready_in_flight", {30'd0, ready, busy}, 32'd1);
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_result();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("quo", quo, e.quo);
      check("rem", rem, e.rem);
      check("div_err", div_err, e.err);
      @(posedge clk); #1;
      check("done_single_pulse", done, 32'd0);
      check("ready_after_done", ready, 32'd1);
      check("quo_held", quo, e.quo);
      check("rem_held", rem, e.rem);
    end
  endtask

  // exp_lat > 0: exact done latency in edges after the start edge; 0: short error path
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int exp_lat);
    int lat;
    @(negedge clk);
    din_A = a; din_B = b; is_signed = s; start = 1'b1;
    sb_q.push_back(model(a, b, s));
    @(posedge clk); #1;
    start = 1'b0;
    din_A = W'($urandom); din_B = W'($urandom); is_signed = ~s;
    wait_done(lat);
    if (lat != 0) begin
      check("done_busy_ready", {30'd0, ready, busy}, 32'd0);
      if (exp_lat > 0) check("latency", lat, exp_lat);
      else             check("latency_div0_short", 32'(lat <= 2), 32'd1);
    end
    compare_result();
  endtask

  initial begin
    logic [W-1:0] corners [5];
    int           lat;
    int           done_seen;
    logic [W-1:0] ra, rb;
    logic         rs;
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFF;

    repeat (2) @(posedge clk);
    #1;
    check("rst_quo", quo, 32'd0);
    check("rst_rem", rem, 32'd0);
    check("rst_flags", {28'd0, ready, busy, done, div_err}, 32'h8);
    @(negedge clk); rst_n = 1'b1;

    do_op(8'd100, 8'd7, 1'b0, 10);
    do_op(8'd55, 8'd0, 1'b0, 0);
    do_op(8'd55, 8'd0, 1'b1, 0);
    do_op(8'd9, 8'd3, 1'b0, 10);
    do_op(8'hF9, 8'd2, 1'b1, 10);
    do_op(8'd7, 8'hFE, 1'b1, 10);
    do_op(8'h80, 8'hFF, 1'b1, 10);
    do_op(8'hF9, 8'd2, 1'b0, 10);

    // second start while busy must be ignored
    @(negedge clk);
    din_A = 8'd200; din_B = 8'd10; is_signed = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'd200, 8'd10, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ready_low_midop", ready, 32'd0);
    din_A = 8'd1; din_B = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    if (lat != 0) check("handshake_latency", lat, 32'd6);
    compare_result();
    check("sb_empty_handshake", sb_q.size(), 32'd0);

    // reset mid-operation aborts
    @(negedge clk);
    din_A = 8'd250; din_B = 8'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_quo", quo, 32'd0);
    check("abort_rem", rem, 32'd0);
    check("abort_flags", {28'd0, ready, busy, done, div_err}, 32'h8);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);
    check("abort_ready", ready, 32'd1);
    do_op(8'd250, 8'd3, 1'b0, 10);

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int s = 0; s < 2; s++)
          do_op(corners[i], corners[j], s[0], (corners[j] == 8'h00) ? 0 : 10);

    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = (i % 37 == 0) ? 8'h00 : W'($urandom);
      rs = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, (rb == 8'h00) ? 0 : 10);
    end

    check("sb_empty_end", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
